// File: rtl/ui_serial_rx.sv
// ui_serial_rx: 8N1 serial byte receiver with a one-entry
// valid/ready holding register, framing-error and overrun flags.
module ui_serial_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_pin,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_err,
  output logic       overrun
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);

  state_t      state, state_d;
  logic        s1, rxs;
  logic [15:0] cnt, cnt_d;
  logic [2:0]  idx, idx_d;
  logic [7:0]  sh, sh_d;
  logic        done, ferr;
  logic        hs;

  assign hs = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= 1'b1;
      rxs <= 1'b1;
    end else begin
      s1  <= rx_pin;
      rxs <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      sh    <= sh_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    sh_d    = sh;
    done    = 1'b0;
    ferr    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rxs) begin
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cnt == HALF) begin
          if (rxs) begin
            state_d = IDLE;
          end else begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = DATA;
          end
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      DATA: begin
        if (cnt == FULL) begin
          sh_d[idx] = rxs;
          cnt_d     = '0;
          if (idx == 3'd7) state_d = STOP;
          else idx_d = idx + 3'd1;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      STOP: begin
        if (cnt == FULL) begin
          cnt_d = '0;
          if (rxs) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr    = 1'b1;
            state_d = BRK;
          end
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      // hold off until a break releases, so it is not seen as a start
      BRK: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr;
      if (done && (!out_valid || out_ready)) begin
        out_data  <= sh;
        out_valid <= 1'b1;
      end else if (hs) begin
        out_valid <= 1'b0;
      end
      if (done && out_valid && !out_ready) overrun <= 1'b1;
      else if (hs) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ui_serial_rx.sv
// tb_ui_serial_rx: directed frames against ui_serial_rx
// with hand-computed expected bytes, flags and latency.
module tb_ui_serial_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_pin;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       frame_err;
  logic       overrun;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int t_start;
  int first_v;
  int v_cnt;
  int fe_cnt;
  logic [7:0] last_data;

  ui_serial_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_pin(rx_pin),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) begin
      v_cnt++;
      last_data = out_data;
      if (first_v < 0) first_v = cyc;
    end
    if (frame_err) fe_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    v_cnt     = 0;
    fe_cnt    = 0;
    first_v   = -1;
    last_data = 8'h00;
  endtask

  task automatic send_bit(input logic b);
    rx_pin = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_data(input logic [7:0] d);
    t_start = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_data(d);
    send_bit(1'b1);
  endtask

  task automatic idle(input int bits);
    rx_pin = 1'b1;
    repeat (bits * CPB) @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    rx_pin    = 1'b1;
    out_ready = 1'b0;
    clr();
    repeat (3) @(negedge clk);
    chk("rst_data", out_data, 8'h00);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    rst_n = 1'b1;
    idle(2);

    // basic byte, consumer always ready
    out_ready = 1'b1;
    clr();
    send_frame(8'hA5);
    idle(2);
    chk("a5_data", last_data, 8'hA5);
    chk("a5_vcyc", v_cnt, 1);
    chk("a5_lat", first_v - t_start, 155);
    chk("a5_ferr", fe_cnt, 0);
    chk("a5_ovr", overrun, 1'b0);

    // short glitch is rejected at the half-bit check
    clr();
    rx_pin = 1'b0;
    repeat (6) @(negedge clk);
    idle(3);
    chk("glitch_v", v_cnt, 0);
    chk("glitch_fe", fe_cnt, 0);
    send_frame(8'h3C);
    idle(2);
    chk("3c_data", last_data, 8'h3C);

    // stop bit held low for two bit-times
    clr();
    send_data(8'h55);
    send_bit(1'b0);
    send_bit(1'b0);
    idle(2);
    chk("brk_fe", fe_cnt, 1);
    chk("brk_v", v_cnt, 0);
    clr();
    send_frame(8'h81);
    idle(2);
    chk("81_data", last_data, 8'h81);
    chk("81_fe", fe_cnt, 0);

    // overrun with back-to-back frames
    out_ready = 1'b0;
    send_frame(8'h11);
    send_frame(8'h22);
    idle(2);
    chk("ovr_valid", out_valid, 1'b1);
    chk("ovr_data", out_data, 8'h11);
    chk("ovr_flag", overrun, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("ovr_cons_v", out_valid, 1'b0);
    chk("ovr_cons_o", overrun, 1'b0);

    // completion coincides with consumption of previous byte
    send_frame(8'h5A);
    idle(1);
    chk("pre_data", out_data, 8'h5A);
    fork
      send_frame(8'hC3);
      begin
        repeat (154) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("same_v", out_valid, 1'b1);
        chk("same_data", out_data, 8'hC3);
        chk("same_ovr", overrun, 1'b0);
      end
    join
    out_ready = 1'b1;
    @(negedge clk);
    chk("same_cons", out_valid, 1'b0);

    // reset in the middle of data bit 4
    out_ready = 1'b0;
    send_frame(8'h77);
    idle(1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rx_pin = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_data", out_data, 8'h00);
    chk("mrst_valid", out_valid, 1'b0);
    chk("mrst_ferr", frame_err, 1'b0);
    chk("mrst_ovr", overrun, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    out_ready = 1'b1;
    clr();
    send_frame(8'h0F);
    idle(2);
    chk("0f_data", last_data, 8'h0F);
    chk("0f_vcyc", v_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
